stage_arb: RTL and testbench

- Clocked two-producer arbiter in front of one 4-phase bundled-data pipeline stage (3-bit data, Rin/Ain request/acknowledge pairs).
- Each producer runs its own 4-phase handshake with the arbiter.
- The arbiter grants one producer at a time, round-robin, and forwards that producer's data and handshake to the stage.
- All asynchronous handshake inputs pass through on-chip synchronizers; a timeout monitor flags a stage that never acknowledges.

---
 rtl/stage_arb_pkg.sv | 8 +
 rtl/stage_sync.sv | 16 +
 rtl/stage_arb.sv | 113 +++++++++++
 tb/tb_stage_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/stage_arb_pkg.sv
// stage_arb_pkg: shared state encoding, grant codes and default data width
package stage_arb_pkg;
    typedef enum logic [1:0] {IDLE, SEND, HOLD, RTZ} state_t;
    localparam int DW_DEF = 3;
    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_P0   = 2'b01;
    localparam logic [1:0] G_P1   = 2'b10;
endpackage

// File: rtl/stage_sync.sv
// stage_sync: N-flop synchronizer chain for one asynchronous handshake input
module stage_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [N-1:0] r_q;
    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else     r_q <= {r_q[N-2:0], i_d};
    end
    assign o_q = r_q[N-1];
endmodule

// File: rtl/stage_arb.sv
// stage_arb: round-robin arbiter forwarding one of two 4-phase producers to a
// bundled-data pipeline stage, with synchronized handshakes and a send timeout.
module stage_arb import stage_arb_pkg::*; #(
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Rin0,
    output logic          Aout0,
    input  logic [DW-1:0] data_in0,
    input  logic          Rin1,
    output logic          Aout1,
    input  logic [DW-1:0] data_in1,
    output logic          Rout,
    input  logic          Ain,
    output logic [DW-1:0] data_out,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    logic w_r0_s, w_r1_s, w_ain_s, w_pick1, w_rg_s;
    state_t r_state, w_state_nx;
    logic [1:0] r_grant, w_grant_nx;
    logic r_rout, w_rout_nx, r_aout0, w_aout0_nx, r_aout1, w_aout1_nx;
    logic r_last, w_last_nx, r_err, w_err_nx;
    logic [DW-1:0] r_data, w_data_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;

    stage_sync #(.N(SYNC_STAGES)) u_sync_r0  (.clk(clk), .rst(rst), .i_d(Rin0), .o_q(w_r0_s));
    stage_sync #(.N(SYNC_STAGES)) u_sync_r1  (.clk(clk), .rst(rst), .i_d(Rin1), .o_q(w_r1_s));
    stage_sync #(.N(SYNC_STAGES)) u_sync_ain (.clk(clk), .rst(rst), .i_d(Ain),  .o_q(w_ain_s));

    // On a tie the producer that was not served last wins.
    assign w_pick1 = w_r1_s & (~w_r0_s | ~r_last);
    assign w_rg_s  = r_grant[1] ? w_r1_s : w_r0_s;

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_rout_nx  = r_rout;
        w_aout0_nx = r_aout0;
        w_aout1_nx = r_aout1;
        w_last_nx  = r_last;
        w_data_nx  = r_data;
        w_err_nx   = r_err;
        w_cnt_nx   = '0;
        case (r_state)
            IDLE: if (w_r0_s | w_r1_s) begin
                w_state_nx = SEND;
                w_grant_nx = w_pick1 ? G_P1 : G_P0;
                w_data_nx  = w_pick1 ? data_in1 : data_in0;
                w_rout_nx  = 1'b1;
            end
            SEND: if (w_ain_s) begin
                w_state_nx = HOLD;
                w_aout0_nx = r_grant[0];
                w_aout1_nx = r_grant[1];
            end else begin
                w_cnt_nx = (r_cnt == TMAX) ? r_cnt : r_cnt + 1'b1;
                w_err_nx = r_err | (w_cnt_nx == TMAX);
            end
            HOLD: if (!w_rg_s) begin
                w_state_nx = RTZ;
                w_rout_nx  = 1'b0;
            end
            RTZ: if (!w_ain_s) begin
                w_state_nx = IDLE;
                w_aout0_nx = 1'b0;
                w_aout1_nx = 1'b0;
                w_last_nx  = r_grant[1];
                w_grant_nx = G_NONE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= G_NONE;
            r_rout  <= 1'b0;
            r_aout0 <= 1'b0;
            r_aout1 <= 1'b0;
            r_last  <= 1'b1;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_rout  <= w_rout_nx;
            r_aout0 <= w_aout0_nx;
            r_aout1 <= w_aout1_nx;
            r_last  <= w_last_nx;
            r_data  <= w_data_nx;
            r_err   <= w_err_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign Rout     = r_rout;
    assign Aout0    = r_aout0;
    assign Aout1    = r_aout1;
    assign data_out = r_data;
    assign grant    = r_grant;
    assign busy     = (r_state != IDLE);
    assign err      = r_err;
endmodule

// File: tb/tb_stage_arb.sv
// tb_stage_arb: vector table for one full handshake plus directed sequences
// for tie-break, fairness, early withdraw, timeout and reset abort.
module tb_stage_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic Rin0 = 1'b0, Rin1 = 1'b0, Ain = 1'b0;
    logic [2:0] data_in0 = 3'b000, data_in1 = 3'b000;
    logic Aout0, Aout1, Rout, busy, err;
    logic [2:0] data_out;
    logic [1:0] grant;

    stage_arb #(.DW(3), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .Rin0(Rin0), .Aout0(Aout0), .data_in0(data_in0),
        .Rin1(Rin1), .Aout1(Aout1), .data_in1(data_in1),
        .Rout(Rout), .Ain(Ain), .data_out(data_out),
        .grant(grant), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rin0, rin1, ain;
        logic [2:0] d0;
        logic       rout, aout0, aout1;
        logic [1:0] grant;
        logic       busy, err;
        logic [2:0] dout;
    } vec_t;

    int checks = 0, errors = 0;
    int overlap = 0, unstable = 0, dly = 0, n_tx = 0, base = 0;
    logic auto_ack = 1'b0, en0 = 1'b0, en1 = 1'b0, want0 = 1'b0, want1 = 1'b0;
    logic aout1_seen = 1'b0, prev_rout = 1'b0;
    logic [2:0] prev_dout = 3'b000;
    logic [1:0] prev_grant = 2'b00;
    logic [1:0] g_log [64];
    logic [2:0] d_log [64];
    vec_t vecs [14];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // One clock: advance stage/producer models and the invariant monitors.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            if (Rout != Ain) begin
                dly++;
                if (dly >= 3) begin Ain = Rout; dly = 0; end
            end else dly = 0;
        end
        if (en0) begin
            if (Rin0 && Aout0) Rin0 = 1'b0;
            else if (!Rin0 && !Aout0 && want0) Rin0 = 1'b1;
        end
        if (en1) begin
            if (Rin1 && Aout1) Rin1 = 1'b0;
            else if (!Rin1 && !Aout1 && want1) Rin1 = 1'b1;
        end
        if (Aout0 && Aout1) overlap++;
        if (Aout1) aout1_seen = 1'b1;
        if (prev_rout && Rout && data_out != prev_dout) unstable++;
        if (grant != 2'b00 && prev_grant == 2'b00 && n_tx < 64) begin
            g_log[n_tx] = grant;
            d_log[n_tx] = data_out;
            n_tx++;
        end
        prev_rout = Rout;
        prev_dout = data_out;
        prev_grant = grant;
    endtask

    initial begin
        //            rin0  rin1  ain   d0      rout  a0    a1    grant  busy  err   dout
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 3'b101};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 3'b101};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 3'b101};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 3'b101};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'b101};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'b101};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'b101};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'b101};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'b101};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'b101};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b101};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b101};

        tick();
        tick();
        chk("reset_state", {Rout, Aout0, Aout1, grant, busy, err, data_out}, 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            Rin0 = vecs[i].rin0;
            Rin1 = vecs[i].rin1;
            Ain = vecs[i].ain;
            data_in0 = vecs[i].d0;
            tick();
            chk($sformatf("vec%0d", i), {Rout, Aout0, Aout1, grant, busy, err, data_out},
                {vecs[i].rout, vecs[i].aout0, vecs[i].aout1, vecs[i].grant,
                 vecs[i].busy, vecs[i].err, vecs[i].dout});
        end

        // Tie right after reset, then continuous requests from both producers.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        auto_ack = 1'b1;
        data_in0 = 3'b001;
        data_in1 = 3'b110;
        base = n_tx;
        Rin0 = 1'b1; Rin1 = 1'b1;
        en0 = 1'b1; en1 = 1'b1; want0 = 1'b1; want1 = 1'b1;
        for (int k = 0; k < 1500 && n_tx < base + 8; k++) tick();
        chk("fair_tx_count", n_tx - base >= 8, 1);
        want0 = 1'b0; want1 = 1'b0;
        for (int k = 0; k < 300 && (Rin0 || Rin1 || busy); k++) tick();
        chk("fair_settle", {Rin0, Rin1, busy}, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fair_grant%0d", i), g_log[base + i], (i % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("fair_data%0d", i), d_log[base + i], (i % 2 == 0) ? 3'b001 : 3'b110);
        end
        repeat (5) tick();

        // Producer 1 flashes a one-cycle request while producer 0 is being served.
        en1 = 1'b0;
        aout1_seen = 1'b0;
        data_in0 = 3'b011;
        base = n_tx;
        Rin0 = 1'b1;
        for (int k = 0; k < 50 && !Rout; k++) tick();
        chk("wd_rout_up", Rout, 1);
        Rin1 = 1'b1;
        tick();
        Rin1 = 1'b0;
        for (int k = 0; k < 200 && (busy || Rin0); k++) tick();
        repeat (10) tick();
        chk("wd_tx_count", n_tx - base, 1);
        chk("wd_grant", g_log[base], 2'b01);
        chk("wd_no_aout1", aout1_seen, 0);
        chk("wd_idle", {busy, grant}, 0);

        // Stage never acknowledges until released.
        auto_ack = 1'b0;
        data_in0 = 3'b010;
        Rin0 = 1'b1;
        for (int k = 0; k < 50 && !Rout; k++) tick();
        chk("to_rout_up", Rout, 1);
        chk("to_err_at_rise", err, 0);
        repeat (7) tick();
        chk("to_err_before", err, 0);
        tick();
        chk("to_err_set", err, 1);
        chk("to_rout_held", Rout, 1);
        repeat (4) tick();
        chk("to_still_send", {Rout, Aout0, err, data_out}, {1'b1, 1'b0, 1'b1, 3'b010});
        auto_ack = 1'b1;
        for (int k = 0; k < 200 && (busy || Rin0); k++) tick();
        chk("to_completes", busy, 0);
        chk("to_err_sticky", err, 1);
        repeat (5) tick();

        // Reset while holding the acknowledge to producer 0.
        en0 = 1'b0;
        data_in0 = 3'b100;
        Rin0 = 1'b1;
        for (int k = 0; k < 100 && !Aout0; k++) tick();
        chk("rst_hold_reached", Aout0, 1);
        rst = 1'b1;
        tick();
        chk("rst_abort", {Rout, Aout0, Aout1, grant, busy, err}, 0);
        rst = 1'b0;
        Rin0 = 1'b0;
        repeat (10) tick();
        data_in1 = 3'b111;
        en1 = 1'b1;
        want1 = 1'b0;
        Rin1 = 1'b1;
        for (int k = 0; k < 50 && grant == 2'b00; k++) tick();
        chk("rst_new_grant", grant, 2'b10);
        chk("rst_new_data", data_out, 3'b111);
        for (int k = 0; k < 200 && (busy || Rin1); k++) tick();
        chk("rst_new_done", {busy, Aout1, Rout}, 0);

        chk("aout_overlap", overlap, 0);
        chk("bundle_stable", unstable, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
